// File: rtl/uncenter_scale_pkg.sv
// Shared widths, fixed-point constants, state encoding and the output clamp
// for the un-center/un-scale datapath.
package uncenter_scale_pkg;

    localparam int Z_W        = 32;
    localparam int ADC_W      = 21;
    localparam int PROD_W     = 64;
    localparam int SUM_W      = 41;
    localparam int Z_FRAC     = 24;
    localparam int MS_FRAC    = 11;
    localparam int ADC_MAX    = 2097151;
    localparam int MUL_CYCLES = 32;
    localparam int CNT_W      = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    localparam logic signed [SUM_W-1:0] ADC_MAX_S = SUM_W'(ADC_MAX);

    typedef struct packed {
        logic             sat;
        logic [ADC_W-1:0] x;
    } adc_res_t;

    // Clamp a rounded Q29.0 result into the unsigned ADC code range.
    function automatic adc_res_t sat_adc(input logic signed [SUM_W-1:0] r);
        adc_res_t res;
        res.sat = 1'b0;
        res.x   = r[ADC_W-1:0];
        if (r[SUM_W-1]) begin
            res.sat = 1'b1;
            res.x   = '0;
        end else if (r > ADC_MAX_S) begin
            res.sat = 1'b1;
            res.x   = ADC_W'(ADC_MAX);
        end
        return res;
    endfunction

endpackage

// File: rtl/uncenter_scale_if.sv
// Sample-in / code-out bundle between the upstream stage and uncenter_scale.
interface uncenter_scale_if;
    import uncenter_scale_pkg::*;

    logic [Z_W-1:0]   z_i;
    logic             srdyi;
    logic [Z_W-1:0]   mean;
    logic [Z_W-1:0]   std;
    logic [ADC_W-1:0] x_adc_o;
    logic             srdyo_o;
    logic             busy_o;
    logic             sat_o;

    modport master (
        output z_i, srdyi, mean, std,
        input  x_adc_o, srdyo_o, busy_o, sat_o
    );

    modport slave (
        input  z_i, srdyi, mean, std,
        output x_adc_o, srdyo_o, busy_o, sat_o
    );

endinterface

// File: rtl/uncenter_scale_mult.sv
// Unsigned 32x32 shift-add multiplier, one multiplier bit per clock.
// done is high during the edge that retires the last bit, so product is
// complete in the cycle after done.
module serial_mult32
    import uncenter_scale_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [Z_W-1:0]    a,
    input  logic [Z_W-1:0]    b,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] acc;
    logic [Z_W-1:0]    mplier;
    logic [CNT_W-1:0]  cnt;
    logic              run;

    assign done    = run && (cnt == CNT_W'(MUL_CYCLES - 1));
    assign product = acc;

    // Load operands on start, then add-and-shift one bit per cycle.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{(PROD_W-Z_W){1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uncenter_scale.sv
// Inverse of the center/scale stage: x = sat(round(z*std + mean)).
//
// state | meaning
// IDLE  | waiting for srdyi; accepts a sample and starts the multiplier
// MUL   | 32 serial shift-add cycles of |z|*std
// ACC   | apply sign, align Q29.35 -> Q29.11 with rounding, add mean
// OUT   | round to integer code, clamp, pulse srdyo_o
module uncenter_scale
    import uncenter_scale_pkg::*;
(
    input  logic              clk,
    input  logic              GlobalReset,
    uncenter_scale_if.slave   bus
);

    localparam logic signed [PROD_W-1:0] RND_Z  = 64'sd8388608;
    localparam logic signed [SUM_W-1:0]  RND_MS = 41'sd1024;

    logic [1:0]               state;
    logic                     sign_q;
    logic [Z_W-1:0]           mean_q;
    logic signed [SUM_W-1:0]  sum_q;
    logic [ADC_W-1:0]         x_q;
    logic                     sat_q;
    logic                     srdyo_q;

    logic                     accept;
    logic [Z_W-1:0]           z_mag;
    logic                     mult_done;
    logic [PROD_W-1:0]        mult_prod;
    logic signed [PROD_W-1:0] p_signed;
    logic signed [SUM_W-1:0]  p_aligned;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  r_full;
    adc_res_t                 res;

    assign accept = (state == ST_IDLE) && bus.srdyi;
    // Two's-complement negate also maps 0x80000000 to its correct magnitude 2^31.
    assign z_mag  = bus.z_i[Z_W-1] ? (~bus.z_i + Z_W'(1)) : bus.z_i;

    serial_mult32 u_mult (
        .clk     (clk),
        .rst_b   (GlobalReset),
        .start   (accept),
        .a       (z_mag),
        .b       (bus.std),
        .done    (mult_done),
        .product (mult_prod)
    );

    // Signed alignment, rounding and clamp; the sum stays exact in 41 bits.
    always_comb begin
        p_signed  = sign_q ? -$signed(mult_prod) : $signed(mult_prod);
        p_aligned = SUM_W'((p_signed + RND_Z) >>> Z_FRAC);
        sum_next  = p_aligned + $signed({{(SUM_W-Z_W){1'b0}}, mean_q});
        r_full    = (sum_q + RND_MS) >>> MS_FRAC;
        res       = sat_adc(r_full);
    end

    // Sequencer plus registered result; srdyo_o pulses for one cycle leaving OUT.
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state   <= ST_IDLE;
            sign_q  <= 1'b0;
            mean_q  <= '0;
            sum_q   <= '0;
            x_q     <= '0;
            sat_q   <= 1'b0;
            srdyo_q <= 1'b0;
        end else begin
            srdyo_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q <= bus.z_i[Z_W-1];
                        mean_q <= bus.mean;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mult_done) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    sum_q <= sum_next;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    x_q     <= res.x;
                    sat_q   <= res.sat;
                    srdyo_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.x_adc_o = x_q;
    assign bus.sat_o   = sat_q;
    assign bus.srdyo_o = srdyo_q;
    assign bus.busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_uncenter_scale.sv
// Directed bench for uncenter_scale: vector table plus busy, reset and
// back-to-back sequences.
module tb_uncenter_scale;

    logic clk = 1'b0;
    logic GlobalReset;

    uncenter_scale_if bus ();

    uncenter_scale dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] z;
        logic [31:0] mean;
        logic [31:0] stdv;
        logic [20:0] x;
        logic        sat;
    } vec_t;

    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive_ops(input logic [31:0] z, input logic [31:0] m, input logic [31:0] s);
        bus.z_i   = z;
        bus.mean  = m;
        bus.std   = s;
        bus.srdyi = 1'b1;
    endtask

    // Consumes the accepting edge, scrambles operands, waits for srdyo_o.
    task automatic wait_result(output logic [20:0] x, output logic sat, output int lat);
        @(posedge clk);
        #1;
        bus.srdyi = 1'b0;
        bus.z_i   = ~bus.z_i;
        bus.mean  = bus.mean ^ 32'h5A5A_5A5A;
        bus.std   = bus.std + 32'd12345;
        lat = -1;
        x   = '0;
        sat = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.srdyo_o) begin
                lat = k;
                x   = bus.x_adc_o;
                sat = bus.sat_o;
                break;
            end
        end
    endtask

    task automatic run_sample(input logic [31:0] z, input logic [31:0] m, input logic [31:0] s,
                              output logic [20:0] x, output logic sat, output int lat);
        @(negedge clk);
        drive_ops(z, m, s);
        wait_result(x, sat, lat);
    endtask

    initial begin
        logic [20:0] x;
        logic        sat;
        int          lat;
        int          pulses;

        vecs[0]  = '{"zero_z",        32'h0000_0000, 32'h001F_4000, 32'h0000_8000, 21'd1000,    1'b0};
        vecs[1]  = '{"one_z",         32'h0100_0000, 32'h001F_4000, 32'h0000_8000, 21'd1016,    1'b0};
        vecs[2]  = '{"neg_2p5",       32'hFD80_0000, 32'h001F_4000, 32'h0003_2000, 21'd750,     1'b0};
        vecs[3]  = '{"rnd_half_up",   32'h0080_0000, 32'h0000_0000, 32'h0000_0800, 21'd1,       1'b0};
        vecs[4]  = '{"rnd_neg_half",  32'hFF80_0000, 32'h0000_0000, 32'h0000_0800, 21'd0,       1'b0};
        vecs[5]  = '{"sat_high",      32'h7F00_0000, 32'h0000_0000, 32'h8000_0000, 21'd2097151, 1'b1};
        vecs[6]  = '{"sat_low",       32'hFF00_0000, 32'h0000_2800, 32'h0000_5000, 21'd0,       1'b1};
        vecs[7]  = '{"std_zero",      32'h8000_0000, 32'h0001_2345, 32'h0000_0000, 21'd36,      1'b0};
        vecs[8]  = '{"mean_at_max",   32'h0000_0000, 32'hFFFF_F800, 32'h0000_1234, 21'd2097151, 1'b0};
        vecs[9]  = '{"mean_over_max", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 21'd2097151, 1'b1};
        vecs[10] = '{"mean_half",     32'h0000_0000, 32'h0000_0400, 32'h0000_0000, 21'd1,       1'b0};
        vecs[11] = '{"two_x_three",   32'h0200_0000, 32'h0000_0000, 32'h0000_1800, 21'd6,       1'b0};
        vecs[12] = '{"zmin_cancel",   32'h8000_0000, 32'h0004_0000, 32'h0000_0800, 21'd0,       1'b0};

        GlobalReset = 1'b0;
        bus.srdyi   = 1'b0;
        bus.z_i     = '0;
        bus.mean    = '0;
        bus.std     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x",     64'(bus.x_adc_o), 64'd0);
        check("rst_sat",   64'(bus.sat_o),   64'd0);
        check("rst_srdyo", 64'(bus.srdyo_o), 64'd0);
        check("rst_busy",  64'(bus.busy_o),  64'd0);
        @(negedge clk);
        GlobalReset = 1'b1;

        foreach (vecs[i]) begin
            run_sample(vecs[i].z, vecs[i].mean, vecs[i].stdv, x, sat, lat);
            check({vecs[i].name, "_x"},   64'(x),   64'(vecs[i].x));
            check({vecs[i].name, "_sat"}, 64'(sat), 64'(vecs[i].sat));
            check({vecs[i].name, "_lat"}, 64'(lat), 64'd34);
        end

        // srdyi while busy is dropped
        @(negedge clk);
        drive_ops(32'h0100_0000, 32'h001F_4000, 32'h0000_8000);
        @(posedge clk);
        #1;
        bus.srdyi = 1'b0;
        pulses = 0;
        lat    = -1;
        x      = '0;
        sat    = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) drive_ops(32'h7F00_0000, 32'h0000_0000, 32'h8000_0000);
            if (k == 5) begin
                bus.srdyi = 1'b0;
                check("busy_mid", 64'(bus.busy_o), 64'd1);
            end
            if (bus.srdyo_o) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    x   = bus.x_adc_o;
                    sat = bus.sat_o;
                end
            end
        end
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_lat",    64'(lat),    64'd34);
        check("busy_x",      64'(x),      64'd1016);
        check("busy_sat",    64'(sat),    64'd0);

        // Leave a saturated result in the output registers, then reset mid-sample
        run_sample(vecs[5].z, vecs[5].mean, vecs[5].stdv, x, sat, lat);
        check("pre_rst_sat", 64'(sat), 64'd1);
        @(negedge clk);
        drive_ops(vecs[2].z, vecs[2].mean, vecs[2].stdv);
        @(posedge clk);
        #1;
        bus.srdyi = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
        end
        GlobalReset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_x",     64'(bus.x_adc_o), 64'd0);
        check("mid_rst_sat",   64'(bus.sat_o),   64'd0);
        check("mid_rst_srdyo", 64'(bus.srdyo_o), 64'd0);
        check("mid_rst_busy",  64'(bus.busy_o),  64'd0);
        GlobalReset = 1'b1;
        drive_ops(vecs[1].z, vecs[1].mean, vecs[1].stdv);
        wait_result(x, sat, lat);
        check("post_rst_lat", 64'(lat), 64'd34);
        check("post_rst_x",   64'(x),   64'd1016);
        check("post_rst_sat", 64'(sat), 64'd0);

        // srdyi held high for 100 edges: accepts at edges 0, 35, 70
        @(negedge clk);
        drive_ops(vecs[0].z, vecs[0].mean, vecs[0].stdv);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_busy_%0d", k),  64'(bus.busy_o),  64'((k % 35) != 34));
            check($sformatf("b2b_srdyo_%0d", k), 64'(bus.srdyo_o), 64'((k % 35) == 34));
            if ((k % 35) == 34) begin
                check($sformatf("b2b_x_%0d", k), 64'(bus.x_adc_o), 64'd1000);
            end
        end
        bus.srdyi = 1'b0;
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/uncenter_scale.md
UNCENTER_SCALE -- requirements
Module: uncenter_scale

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 GlobalReset  input  1  synchronous reset, active-low (0 = reset).
REQ-004 z_i  input  32  centered/scaled sample, signed two's complement Q8.24.
REQ-005 srdyi  input  1  z_i/mean/std valid this cycle.
REQ-006 mean  input  32  unsigned Q21.11 offset, in ADC LSBs.
REQ-007 std  input  32  unsigned Q21.11 scale, in ADC LSBs.
REQ-008 x_adc_o  output  21  reconstructed unsigned ADC code.
REQ-009 srdyo_o  output  1  one-cycle pulse; x_adc_o/sat_o valid.
REQ-010 busy_o  output  1  high whenever state != IDLE.
REQ-011 sat_o  output  1  result was clamped; valid with srdyo_o.

Function
REQ-012 Computation SHALL be x = sat(round(z*std + mean)), the inverse of the center/scale stage.
REQ-013 States SHALL be IDLE, MUL, ACC, OUT; the only other transitions are IDLE->MUL, MUL->ACC, ACC->OUT, OUT->IDLE.
REQ-014 IDLE: on an edge with srdyi=1, capture z_i, mean, std, sign(z_i) and |z_i|; clear counter; go to MUL.
REQ-015 MUL: unsigned serial shift-add of |z|*std, one bit per cycle; exactly 32 cycles; then go to ACC.
REQ-016 ACC: signed product P (64 b, Q29.35) = sign ? -mag : mag; S = ((P + 2^23) >>> 24) + zero-extended mean, 41 b signed, Q29.11.
REQ-017 OUT: R = (S + 2^10) >>> 11, round half up; register x_adc_o and sat_o; srdyo_o=1 for this cycle only; return to IDLE.
REQ-018 Saturation: R<0 -> x_adc_o=0, sat_o=1; R>2097151 -> x_adc_o=2097151, sat_o=1; otherwise x_adc_o=R[20:0], sat_o=0.
REQ-019 Latency: srdyo_o SHALL be high in the cycle following the 34th rising edge after the accepting edge. Throughput SHALL be one sample per 35 cycles.
REQ-020 srdyi while busy_o=1 SHALL be ignored. The sample is dropped, with no queueing and no state change.
REQ-021 In the OUT cycle, srdyi SHALL be ignored. A new sample is accepted only from IDLE.
REQ-022 Operand inputs SHALL be sampled only at the accepting edge. Later changes SHALL NOT affect the result.
REQ-023 x_adc_o and sat_o SHALL hold their last values until the next OUT cycle.
REQ-024 std=0 SHALL yield x = sat(round(mean)) with no special case.

Reset
REQ-025 When GlobalReset=0 at an edge: state=IDLE, counter=0, product accumulator=0, x_adc_o=0, srdyo_o=0, sat_o=0, busy_o=0.
REQ-026 Reset mid-operation SHALL abort the sample with no srdyo_o pulse. srdyi on the first edge after reset release SHALL be accepted.

Structure
REQ-027 A shared package SHALL hold:
- widths: Z_W=32, ADC_W=21, PROD_W=64, SUM_W=41;
- fraction constants: Z_FRAC=24, MS_FRAC=11;
- ADC_MAX=2097151;
- MUL_CYCLES=32;
- state encoding.
REQ-028 The multiplier SHALL be sub-module serial_mult32, an unsigned 32x32 shift-add unit with start/done and a 64-bit product. uncenter_scale SHALL own the sign, alignment, rounding and saturation.

Verification
REQ-029 z=0x00000000, std=0x00008000 (16.0), mean=0x001F4000 (1000.0) -> x_adc_o=1000, sat_o=0, srdyo_o exactly 34 edges after accept.
REQ-030 z=0x01000000 (1.0), std=16.0, mean=1000.0 -> 1016. z=0xFD800000 (-2.5), std=0x00032000 (100.0), mean=1000.0 -> 750.
REQ-031 Rounding:
- z=0x00800000 (0.5), std=0x00000800 (1.0), mean=0 -> 1;
- z=0xFF800000 (-0.5), same std/mean -> 0, sat_o=0.
REQ-032 Saturation:
- z=0x7F000000 (127.0), std=0x80000000 (2^20), mean=0 -> 2097151, sat_o=1;
- z=0xFF000000 (-1.0), std=0x00005000 (10.0), mean=0x00002800 (5.0) -> 0, sat_o=1.
REQ-033 Busy/reset:
- srdyi pulsed at accept+5 with different operands -> ignored; the first result is unchanged and there is exactly one srdyo_o pulse;
- GlobalReset=0 at accept+10 -> all outputs 0 and no pulse;
- a new srdyi after release -> correct result at +34.
REQ-034 Back-to-back: srdyi held at 1 for 100 cycles -> accepts occur every 35 cycles, one srdyo_o per accept, busy_o low only in IDLE cycles.
